// File: rtl/bram_read_sequencer.sv
// Burst read sequencer: turns (addr, len) commands into single-word BRAM read strobes,
// buffers returned words in a small FIFO and streams them out with a last-beat marker.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a command
// ISSUE  | strobe the next word once FIFO credit allows
// WAIT   | read outstanding; wait for controller valid or watchdog expiry
// FLUSH  | zero-length command; single-cycle done pulse
module bram_read_sequencer #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 31,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_din_o,
    input  logic [DATA_WIDTH-1:0] bram_dout_i,
    input  logic                  bram_valid_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   mem_data_q [FIFO_DEPTH];
    logic                    mem_last_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;

    logic accept, credit_ok, push, pop, push_last, timeout_hit;

    // Outstanding reads are only possible in WAIT, so in ISSUE the credit is the FIFO room.
    assign accept      = (state_q == S_IDLE) && cmd_valid_i;
    assign credit_ok   = count_q < CW'(FIFO_DEPTH);
    assign push        = (state_q == S_WAIT) && bram_valid_i;
    assign pop         = (count_q != '0) && m_ready_i;
    assign push_last   = rem_q == LEN_WIDTH'(1);
    assign timeout_hit = (state_q == S_WAIT) && !bram_valid_i && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (cmd_len_i == '0) ? S_FLUSH : S_ISSUE;
            S_ISSUE: if (credit_ok) state_d = S_WAIT;
            S_WAIT: begin
                if (bram_valid_i)     state_d = push_last ? S_IDLE : S_ISSUE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        bram_en_o   = (state_q == S_ISSUE) && credit_ok;
        busy_o      = (state_q != S_IDLE);
        done_o      = done_q || (state_q == S_FLUSH);
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        tmo_d  = '0;
        err_d  = err_q;
        done_d = pop && mem_last_q[rd_ptr_q];
        if (accept) begin
            addr_d = cmd_addr_i;
            rem_d  = cmd_len_i;
            err_d  = 1'b0;
        end else if (push) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end else if (timeout_hit) begin
            err_d  = 1'b1;
            rem_d  = '0;
        end else if (state_q == S_WAIT) begin
            tmo_d  = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            rem_q  <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // Output FIFO; the credit rule guarantees push never sees a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= bram_dout_i;
                mem_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    assign m_valid_o   = (count_q != '0);
    assign m_data_o    = m_valid_o ? mem_data_q[rd_ptr_q] : '0;
    assign m_last_o    = m_valid_o && mem_last_q[rd_ptr_q];
    assign bram_addr_o = addr_q;
    assign bram_we_o   = 1'b0;
    assign bram_din_o  = '0;
    assign err_o       = err_q;

endmodule
